// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - three-channel button synchroniser and debouncer with fire press strobe
module button_debouncer #(
   parameter int STABLE_CYCLES = 250000,
   parameter int CNT_W         = 18,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic clk_25MHz,
   input  logic reset,
   input  logic left_raw,
   input  logic right_raw,
   input  logic fire_raw,
   output logic left_debounced,
   output logic right_debounced,
   output logic fire_debounced,
   output logic fire_pulse
);

   // Last count value before the output is allowed to take the new level.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   // Channel order in the vectors below: 0 = left, 1 = right, 2 = fire.
   logic [2:0] raw;
   logic [2:0] s1;
   logic [2:0] s2;
   logic [2:0] deb;
   logic [2:0] commit;

   // Board buttons may be pulled up; fold that in before synchronising so
   // the reset level of the synchronisers is always "not pressed".
   assign raw = {fire_raw, right_raw, left_raw} ^ {3{ACTIVE_LOW}};

   // Two-flop synchroniser for all three asynchronous button inputs.
   always_ff @(posedge clk_25MHz or negedge reset) begin
      if (!reset) begin
         s1 <= 3'b000;
         s2 <= 3'b000;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   for (genvar ch = 0; ch < 3; ch++) begin : g_chan
      logic             deb_q;
      logic [CNT_W-1:0] cnt_q;

      // The output takes the new level on this edge.
      assign commit[ch] = (s2[ch] != deb_q) && (cnt_q == CNT_LAST);
      assign deb[ch]    = deb_q;

      // Stability counter: any sample matching the output restarts the window.
      always_ff @(posedge clk_25MHz or negedge reset) begin
         if (!reset) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
         end else if (s2[ch] == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            deb_q <= s2[ch];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // One-cycle strobe aligned with the debounced fire rising edge; release is silent.
   always_ff @(posedge clk_25MHz or negedge reset) begin
      if (!reset) begin
         fire_pulse <= 1'b0;
      end else begin
         fire_pulse <= commit[2] & s2[2];
      end
   end

   assign left_debounced  = deb[0];
   assign right_debounced = deb[1];
   assign fire_debounced  = deb[2];

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - randomized scoreboard bench for button_debouncer
module tb_button_debouncer;

   localparam int NCYC = 4000;

   typedef struct packed {
      int         cyc;
      logic [7:0] v;   // {dut1: pulse,fire,right,left, dut0: pulse,fire,right,left}
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic left_raw, right_raw, fire_raw;
   logic l0, r0, f0, p0;
   logic l1, r1, f1, p1;

   int checks = 0;
   int failures = 0;

   exp_t exp_q[$];

   // Reference model state: samples per DUT/channel indexed by edge number.
   bit hist [2][3][0:NCYC+8];
   bit mdeb [2][3];
   bit mpulse [2];
   int stab [2] = '{4, 1};
   bit inv [2] = '{1'b0, 1'b1};
   int last_rst;
   int n;

   always #20 clk = ~clk;

   button_debouncer #(.STABLE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b0)) dut0 (
      .clk_25MHz(clk), .reset(reset),
      .left_raw(left_raw), .right_raw(right_raw), .fire_raw(fire_raw),
      .left_debounced(l0), .right_debounced(r0), .fire_debounced(f0), .fire_pulse(p0)
   );

   button_debouncer #(.STABLE_CYCLES(1), .CNT_W(1), .ACTIVE_LOW(1'b1)) dut1 (
      .clk_25MHz(clk), .reset(reset),
      .left_raw(left_raw), .right_raw(right_raw), .fire_raw(fire_raw),
      .left_debounced(l1), .right_debounced(r1), .fire_debounced(f1), .fire_pulse(p1)
   );

   // Synchronised sample seen as "edge k"; anything at or before a reset edge reads as released.
   function automatic bit sample(input int d, input int c, input int k);
      if (k < 1 || k <= last_rst) return 1'b0;
      return hist[d][c][k];
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 3; c++) mdeb[d][c] = 1'b0;
         mpulse[d] = 1'b0;
      end
   endtask

   // An output adopts a new level once the last STABLE samples that reached the
   // counter (two edges behind the pins) all show that level.
   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         mpulse[d] = 1'b0;
         for (int c = 0; c < 3; c++) begin
            bit v;
            bit flip;
            v = !mdeb[d][c];
            flip = 1'b1;
            for (int k = n - 1 - stab[d]; k <= n - 2; k++)
               if (sample(d, c, k) != v) flip = 1'b0;
            if (flip) begin
               mdeb[d][c] = v;
               if (c == 2 && v) mpulse[d] = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [7:0] model_out();
      return {mpulse[1], mdeb[1][2], mdeb[1][1], mdeb[1][0],
              mpulse[0], mdeb[0][2], mdeb[0][1], mdeb[0][0]};
   endfunction

   task automatic check(input string name, input int cyc, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d actual=%b expected=%b", name, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle presents a fresh output set; compare against the scoreboard.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("dut0_left",  e.cyc, l0, e.v[0]);
         check("dut0_right", e.cyc, r0, e.v[1]);
         check("dut0_fire",  e.cyc, f0, e.v[2]);
         check("dut0_pulse", e.cyc, p0, e.v[3]);
         check("dut1_left",  e.cyc, l1, e.v[4]);
         check("dut1_right", e.cyc, r1, e.v[5]);
         check("dut1_fire",  e.cyc, f1, e.v[6]);
         check("dut1_pulse", e.cyc, p1, e.v[7]);
      end
   end

   // Stimulus and reference model, one step per rising edge.
   initial begin
      int mode;
      int div;
      int rst_left;
      bit raws [3];
      reset = 1'b0;
      left_raw = 1'b1;
      right_raw = 1'b1;
      fire_raw = 1'b1;
      n = 0;
      last_rst = 0;
      mode = 0;
      div = 30;
      rst_left = 0;
      model_reset();
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         n++;
         raws = '{left_raw, right_raw, fire_raw};
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++)
               hist[d][c][n] = raws[c] ^ inv[d];
         if (!reset) begin
            last_rst = n;
            model_reset();
         end else begin
            model_edge();
         end

         // Next inputs: reset held 5 edges with buttons pressed, a long clean
         // hold, then random phases of quiet, bouncy and mixed activity.
         if (cyc == 4) begin
            reset = 1'b1;
         end else if (cyc > 30) begin
            if (cyc % 60 == 0) begin
               mode = $urandom_range(0, 2);
               div = (mode == 0) ? 30 : (mode == 1) ? 3 : 8;
            end
            if (rst_left > 0) begin
               rst_left--;
               if (rst_left == 0) reset = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
               reset = 1'b0;
               rst_left = $urandom_range(1, 3);
            end
            if ($urandom_range(0, div - 1) == 0) left_raw = ~left_raw;
            if ($urandom_range(0, div - 1) == 0) right_raw = ~right_raw;
            if ($urandom_range(0, div - 1) == 0) fire_raw = ~fire_raw;
         end

         if (!reset) begin
            last_rst = n;
            model_reset();
         end
         exp_q.push_back('{cyc: n, v: model_out()});
      end
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
